// File: rtl/axi_lite_arbiter_nm.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_arbiter_nm
// Brief    : N-master to 1-slave AXI-lite arbiter for the shared SRAM port.
//            One complete read or write transaction is granted at a time.
//            The grant is held until the B or R handshake completes.
//            Arbitration is fixed priority (highest index wins) or
//            round-robin, selected by RR_MODE.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter_nm #(
  parameter int NUM_M   = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_M*ADDR_W-1:0]    m_aw_addr,
  input  logic [NUM_M-1:0]           m_aw_valid,
  output logic [NUM_M-1:0]           m_aw_ready,
  input  logic [NUM_M*DATA_W-1:0]    m_w_data,
  input  logic [NUM_M*DATA_W/8-1:0]  m_w_strb,
  input  logic [NUM_M-1:0]           m_w_valid,
  output logic [NUM_M-1:0]           m_w_ready,
  output logic [NUM_M-1:0]           m_b_valid,
  input  logic [NUM_M-1:0]           m_b_ready,
  input  logic [NUM_M*ADDR_W-1:0]    m_ar_addr,
  input  logic [NUM_M-1:0]           m_ar_valid,
  output logic [NUM_M-1:0]           m_ar_ready,
  output logic [DATA_W-1:0]          m_r_data,
  output logic [NUM_M-1:0]           m_r_valid,
  input  logic [NUM_M-1:0]           m_r_ready,
  output logic [ADDR_W-1:0]          s_aw_addr,
  output logic                       s_aw_valid,
  input  logic                       s_aw_ready,
  output logic [DATA_W-1:0]          s_w_data,
  output logic [DATA_W/8-1:0]        s_w_strb,
  output logic                       s_w_valid,
  input  logic                       s_w_ready,
  input  logic                       s_b_valid,
  output logic                       s_b_ready,
  output logic [ADDR_W-1:0]          s_ar_addr,
  output logic                       s_ar_valid,
  input  logic                       s_ar_ready,
  input  logic [DATA_W-1:0]          s_r_data,
  input  logic                       s_r_valid,
  output logic                       s_r_ready,
  output logic [$clog2(NUM_M)-1:0]   grant_idx,
  output logic                       busy
);

  localparam int IDX_W  = $clog2(NUM_M);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   last_grant;
  logic               aw_done;
  logic               w_done;
  logic               aw_done_nxt;
  logic               w_done_nxt;
  logic               grant_en;
  logic [NUM_M-1:0]   req;
  logic [IDX_W-1:0]   winner;
  logic               aw_hs;
  logic               w_hs;

  logic [ADDR_W-1:0]  aw_addr_arr [NUM_M];
  logic [ADDR_W-1:0]  ar_addr_arr [NUM_M];
  logic [DATA_W-1:0]  w_data_arr  [NUM_M];
  logic [STRB_W-1:0]  w_strb_arr  [NUM_M];

  // Split the flat per-master buses into per-master slices
  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign aw_addr_arr[i] = m_aw_addr[i*ADDR_W +: ADDR_W];
    assign ar_addr_arr[i] = m_ar_addr[i*ADDR_W +: ADDR_W];
    assign w_data_arr[i]  = m_w_data[i*DATA_W +: DATA_W];
    assign w_strb_arr[i]  = m_w_strb[i*STRB_W +: STRB_W];
  end

  // Payloads always follow the granted master; valids are gated separately
  assign s_aw_addr = aw_addr_arr[grant_idx];
  assign s_ar_addr = ar_addr_arr[grant_idx];
  assign s_w_data  = w_data_arr[grant_idx];
  assign s_w_strb  = w_strb_arr[grant_idx];
  assign m_r_data  = s_r_data;
  assign busy      = (state != ST_IDLE);
  assign req       = m_aw_valid | m_ar_valid;

  // Pick the winner among current requesters
  always_comb begin
    winner = '0;
    if (RR_MODE != 0) begin
      // Walk backwards so the nearest requester after last_grant is kept
      for (int k = NUM_M; k >= 1; k--) begin
        if (req[(int'(last_grant) + k) % NUM_M]) begin
          winner = IDX_W'((int'(last_grant) + k) % NUM_M);
        end
      end
    end else begin
      // Highest requesting index overrides lower ones
      for (int i = 0; i < NUM_M; i++) begin
        if (req[i]) begin
          winner = IDX_W'(i);
        end
      end
    end
  end

  // State, grant and write-phase flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_M - 1);
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (grant_en) begin
        grant_idx  <= winner;
        last_grant <= winner;
      end
    end
  end

  // Channel forwarding for the granted master and next-state decode
  always_comb begin
    state_nxt   = state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    grant_en    = 1'b0;
    s_aw_valid  = 1'b0;
    s_w_valid   = 1'b0;
    s_b_ready   = 1'b0;
    s_ar_valid  = 1'b0;
    s_r_ready   = 1'b0;
    m_aw_ready  = '0;
    m_w_ready   = '0;
    m_b_valid   = '0;
    m_ar_ready  = '0;
    m_r_valid   = '0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          grant_en  = 1'b1;
          // A master raising AW and AR together gets its write first
          state_nxt = m_aw_valid[winner] ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        s_aw_valid            = ~aw_done & m_aw_valid[grant_idx];
        s_w_valid             = ~w_done & m_w_valid[grant_idx];
        m_aw_ready[grant_idx] = ~aw_done & s_aw_ready;
        m_w_ready[grant_idx]  = ~w_done & s_w_ready;
        aw_hs                 = s_aw_valid & s_aw_ready;
        w_hs                  = s_w_valid & s_w_ready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_nxt = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        s_b_ready            = m_b_ready[grant_idx];
        m_b_valid[grant_idx] = s_b_valid;
        if (s_b_valid & m_b_ready[grant_idx]) begin
          state_nxt   = ST_IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      ST_RD_ADDR: begin
        s_ar_valid            = m_ar_valid[grant_idx];
        m_ar_ready[grant_idx] = s_ar_ready;
        if (m_ar_valid[grant_idx] & s_ar_ready) begin
          state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        s_r_ready            = m_r_ready[grant_idx];
        m_r_valid[grant_idx] = s_r_valid;
        if (s_r_valid & m_r_ready[grant_idx]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
